instr_dcd: RTL

Instruction decoder between the SPI byte bridge and the PWM register file. It turns two-byte SPI frames into single-cycle `read`/`write` strobes with `addr`/`data_write`. For reads, it captures the register file's registered `data_read` into `data_out`, which the bridge shifts back to the host.

---
 rtl/instr_dcd_if.sv | 25 ++
 rtl/instr_dcd.sv | 106 ++++++++++
 2 files changed

// File: rtl/instr_dcd_if.sv
// Bridge/register-file bus seen by the instruction decoder.
// master = decoder side, slave = bridge and register file side.
interface instr_dcd_if;
  logic       byte_sync;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       read;
  logic       write;
  logic [5:0] addr;
  logic [7:0] data_read;
  logic [7:0] data_write;
  logic       busy;

  modport master (
    input  byte_sync, data_in, data_read,
    output data_out, read, write, addr,
    output data_write, busy
  );

  modport slave (
    output byte_sync, data_in, data_read,
    input  data_out, read, write, addr,
    input  data_write, busy
  );
endinterface

// File: rtl/instr_dcd.sv
// Two-byte SPI frame decoder producing read/write strobes.
// Optional WAIT_DATA timeout: define INSTR_DCD_TIMEOUT_EN.
module instr_dcd #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  instr_dcd_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_CAP,
    WAIT_DATA,
    WR
  } state_t;

  state_t state;
  logic   is_wr;

`ifdef INSTR_DCD_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic          expired;

  assign expired = (cnt == CW'(TIMEOUT_CYCLES - 1));
`endif

  // Frame FSM; strobes and busy are registered with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      is_wr          <= 1'b0;
      bus.data_out   <= 8'h00;
      bus.read       <= 1'b0;
      bus.write      <= 1'b0;
      bus.addr       <= 6'd0;
      bus.data_write <= 8'h00;
      bus.busy       <= 1'b0;
`ifdef INSTR_DCD_TIMEOUT_EN
      cnt            <= '0;
`endif
    end else begin
      bus.read  <= 1'b0;
      bus.write <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.byte_sync) begin
            bus.addr <= bus.data_in[5:0];
            is_wr    <= bus.data_in[7];
            bus.busy <= 1'b1;
            if (bus.data_in[7]) begin
              bus.data_out <= 8'h00;
              state        <= WAIT_DATA;
`ifdef INSTR_DCD_TIMEOUT_EN
              cnt          <= '0;
`endif
            end else begin
              bus.read <= 1'b1;
              state    <= RD_REQ;
            end
          end
        end
        RD_REQ: begin
          state <= RD_CAP;
        end
        RD_CAP: begin
          bus.data_out <= bus.data_read;
          state        <= WAIT_DATA;
`ifdef INSTR_DCD_TIMEOUT_EN
          cnt          <= '0;
`endif
        end
        WAIT_DATA: begin
          if (bus.byte_sync) begin
            if (is_wr) begin
              bus.data_write <= bus.data_in;
              bus.write      <= 1'b1;
              state          <= WR;
            end else begin
              bus.busy <= 1'b0;
              state    <= IDLE;
            end
`ifdef INSTR_DCD_TIMEOUT_EN
          end else if (expired) begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
`endif
          end
        end
        WR: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
